// File: rtl/preg_allocator_pkg.sv
// Shared sizing constants and index types for the physical register freelist.
package preg_allocator_pkg;

    localparam int unsigned ALLOC_WIDTH            = 2;
    localparam int unsigned NUM_PREGS              = 64;
    localparam int unsigned NUM_AREGS              = 16;
    localparam int unsigned MAX_PREDICT_DEPTH      = 4;
    localparam int unsigned MAX_PREDICT_DEPTH_BITS = $clog2(MAX_PREDICT_DEPTH);
    localparam int unsigned PREG_BITS              = $clog2(NUM_PREGS);

    typedef logic [PREG_BITS-1:0] preg_t;
    typedef logic [PREG_BITS:0]   fl_ptr_t;
    typedef logic [MAX_PREDICT_DEPTH_BITS-1:0] ckpt_tag_t;

endpackage

// File: rtl/preg_allocator_lane_compact.sv
// Per-lane exclusive prefix count of a request mask, plus the total popcount.
module lane_compact #(
    parameter int unsigned WIDTH    = 2,
    parameter int unsigned CNT_BITS = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0]               mask,
    output logic [WIDTH-1:0][CNT_BITS-1:0] offset,
    output logic [CNT_BITS-1:0]            count
);

    logic [CNT_BITS-1:0] acc;

    always_comb begin
        acc    = '0;
        offset = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            offset[i] = acc;
            acc       = acc + CNT_BITS'(mask[i]);
        end
        count = acc;
    end

endmodule

// File: rtl/preg_allocator.sv
// Circular-FIFO physical register freelist with multi-lane alloc/free and
// branch checkpoints of the head pointer.
module preg_allocator #(
    parameter int unsigned WIDTH                  = preg_allocator_pkg::ALLOC_WIDTH,
    parameter int unsigned NUM_PREGS              = preg_allocator_pkg::NUM_PREGS,
    parameter int unsigned NUM_AREGS              = preg_allocator_pkg::NUM_AREGS,
    parameter int unsigned MAX_PREDICT_DEPTH      = preg_allocator_pkg::MAX_PREDICT_DEPTH,
    parameter int unsigned MAX_PREDICT_DEPTH_BITS = $clog2(MAX_PREDICT_DEPTH),
    parameter int unsigned PREG_BITS              = $clog2(NUM_PREGS)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [WIDTH-1:0]                  alloc_req,
    input  logic                              alloc_valid,
    output logic                              alloc_ready,
    output logic                              alloc_out_valid,
    output logic [WIDTH-1:0][PREG_BITS-1:0]   alloc_preg,
    input  logic [WIDTH-1:0]                  free_valid,
    input  logic [WIDTH-1:0][PREG_BITS-1:0]   free_preg,
    input  logic                              checkpoint_valid,
    input  logic [MAX_PREDICT_DEPTH_BITS-1:0] checkpoint_tag,
    input  logic                              branch_shootdown,
    input  logic [MAX_PREDICT_DEPTH_BITS-1:0] shootdown_branch_tag,
    output logic [PREG_BITS:0]                num_free
);

    localparam int unsigned PTR_BITS = PREG_BITS + 1;
    localparam int unsigned CNT_BITS = $clog2(WIDTH + 1);
    localparam int unsigned NUM_INIT = NUM_PREGS - NUM_AREGS;

    typedef logic [PREG_BITS-1:0] preg_t;
    typedef logic [PTR_BITS-1:0]  ptr_t;

    preg_t fifo_q [NUM_PREGS];
    preg_t fifo_d [NUM_PREGS];
    ptr_t  ckpt_q [MAX_PREDICT_DEPTH];
    ptr_t  ckpt_d [MAX_PREDICT_DEPTH];
    ptr_t  head_q, head_d;
    ptr_t  tail_q, tail_d;
    logic  alloc_out_valid_q, alloc_out_valid_d;
    logic [WIDTH-1:0][PREG_BITS-1:0] alloc_preg_q, alloc_preg_d;

    logic [WIDTH-1:0]               req_mask;
    logic [WIDTH-1:0][CNT_BITS-1:0] alloc_off;
    logic [CNT_BITS-1:0]            alloc_cnt;
    logic [WIDTH-1:0][CNT_BITS-1:0] free_off;
    logic [CNT_BITS-1:0]            free_cnt;
    logic                           grant;

    assign req_mask = alloc_req & {WIDTH{alloc_valid}};

    lane_compact #(.WIDTH(WIDTH), .CNT_BITS(CNT_BITS)) u_alloc_compact (
        .mask   (req_mask),
        .offset (alloc_off),
        .count  (alloc_cnt)
    );

    lane_compact #(.WIDTH(WIDTH), .CNT_BITS(CNT_BITS)) u_free_compact (
        .mask   (free_valid),
        .offset (free_off),
        .count  (free_cnt)
    );

    // The wrap bit makes the modular difference distinguish full from empty.
    assign num_free    = tail_q - head_q;
    assign alloc_ready = (num_free >= ptr_t'(alloc_cnt)) && !branch_shootdown;
    assign grant       = alloc_valid && alloc_ready;

    assign alloc_out_valid = alloc_out_valid_q;
    assign alloc_preg      = alloc_preg_q;

    always_comb begin
        alloc_out_valid_d = grant;
        alloc_preg_d      = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (grant && req_mask[i]) begin
                alloc_preg_d[i] = fifo_q[preg_t'(head_q + ptr_t'(alloc_off[i]))];
            end
        end
    end

    always_comb begin
        head_d = head_q;
        if (branch_shootdown) begin
            head_d = ckpt_q[shootdown_branch_tag];
        end else if (grant) begin
            head_d = head_q + ptr_t'(alloc_cnt);
        end
        ckpt_d = ckpt_q;
        if (checkpoint_valid && !branch_shootdown) begin
            ckpt_d[checkpoint_tag] = head_d;
        end
    end

    // Frees land behind the tail; reads above use fifo_q, so they are only
    // visible to allocation from the next cycle.
    always_comb begin
        fifo_d = fifo_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (free_valid[i]) begin
                fifo_d[preg_t'(tail_q + ptr_t'(free_off[i]))] = free_preg[i];
            end
        end
        tail_d = tail_q + ptr_t'(free_cnt);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_PREGS; i++) begin
                fifo_q[i] <= (i < NUM_INIT) ? preg_t'(i + NUM_AREGS) : '0;
            end
            for (int unsigned i = 0; i < MAX_PREDICT_DEPTH; i++) begin
                ckpt_q[i] <= '0;
            end
            head_q            <= '0;
            tail_q            <= ptr_t'(NUM_INIT);
            alloc_out_valid_q <= 1'b0;
            alloc_preg_q      <= '0;
        end else begin
            fifo_q            <= fifo_d;
            ckpt_q            <= ckpt_d;
            head_q            <= head_d;
            tail_q            <= tail_d;
            alloc_out_valid_q <= alloc_out_valid_d;
            alloc_preg_q      <= alloc_preg_d;
        end
    end

endmodule
